// File: rtl/butterfly_sum.sv
// Radix-2 butterfly: registered component-wise complex sum and difference.
// Define BUTTERFLY_SUM_SAT_EN to saturate each field instead of wrapping.
module butterfly_sum #(
    parameter int WORD_SZ = 8
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic [WORD_SZ-1:0] in1,
    input  logic [WORD_SZ-1:0] in2,
    output logic [WORD_SZ-1:0] out1,
    output logic [WORD_SZ-1:0] out2
);

    localparam int HW = WORD_SZ / 2;

    generate
        if ((WORD_SZ % 2) != 0 || WORD_SZ < 4) begin : g_bad_width
            $error("butterfly_sum: WORD_SZ must be even and >= 4");
        end
    endgenerate

    logic signed [HW-1:0] a_re, a_im, b_re, b_im;
    logic signed [HW:0]   sum_re, sum_im, dif_re, dif_im;
    logic [WORD_SZ-1:0]   sum_nxt, dif_nxt;

    // Reduce a HW+1-bit field result back to HW bits.
    function automatic logic [HW-1:0] reduce(input logic signed [HW:0] v);
`ifdef BUTTERFLY_SUM_SAT_EN
        logic [HW-1:0] r;
        if (v[HW] != v[HW-1])
            r = v[HW] ? {1'b1, {(HW-1){1'b0}}} : {1'b0, {(HW-1){1'b1}}};
        else
            r = v[HW-1:0];
        return r;
`else
        logic [HW:0] t;
        t = v;
        return t[HW-1:0];
`endif
    endfunction

    always_comb begin
        a_re   = in1[WORD_SZ-1:HW];
        a_im   = in1[HW-1:0];
        b_re   = in2[WORD_SZ-1:HW];
        b_im   = in2[HW-1:0];
        sum_re = a_re + b_re;
        sum_im = a_im + b_im;
        dif_re = a_re - b_re;
        dif_im = a_im - b_im;
        sum_nxt = {reduce(sum_re), reduce(sum_im)};
        dif_nxt = {reduce(dif_re), reduce(dif_im)};
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            out1 <= '0;
            out2 <= '0;
        end else begin
            out1 <= sum_nxt;
            out2 <= dif_nxt;
        end
    end

endmodule

// File: tb/tb_butterfly_sum.sv
// Self-checking bench for butterfly_sum: directed cases, random back-to-back
// stream against an integer reference model, and asynchronous reset checks.
module tb_butterfly_sum;

    localparam int W  = 8;
    localparam int HW = W / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [W-1:0] out1, out2;

    int checks   = 0;
    int failures = 0;

    butterfly_sum #(.WORD_SZ(W)) dut (
        .i_CLK  (clk),
        .i_RESET(rst_n),
        .in1    (in1),
        .in2    (in2),
        .out1   (out1),
        .out2   (out2)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [HW-1:0] f);
        int u;
        u = int'(f);
        return (u >= (1 << (HW - 1))) ? u - (1 << HW) : u;
    endfunction

    function automatic logic [HW-1:0] fld(input int v);
        int lo, hi, t;
        lo = -(1 << (HW - 1));
        hi = (1 << (HW - 1)) - 1;
        t  = v;
`ifdef BUTTERFLY_SUM_SAT_EN
        if (t > hi) t = hi;
        if (t < lo) t = lo;
`endif
        return t[HW-1:0];
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        int ar, ai, br, bi;
        ar = sx(a[W-1:HW]);
        ai = sx(a[HW-1:0]);
        br = sx(b[W-1:HW]);
        bi = sx(b[HW-1:0]);
        if (sub) return {fld(ar - br), fld(ai - bi)};
        else     return {fld(ar + br), fld(ai + bi)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] e1, e2;

    initial begin
        // Reset held: outputs stay zero while clock runs.
        in1 = 8'h31;
        in2 = 8'h21;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold_out1", out1, 8'h00);
            check("reset_hold_out2", out2, 8'h00);
        end

        // Release between edges; first edge loads the result.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_pre_edge_out1", out1, 8'h00);
        @(posedge clk);
        #1;
        check("basic_out1", out1, 8'h52);
        check("basic_out2", out2, 8'h10);

        in1 = 8'h1F;
        in2 = 8'h2E;
        @(posedge clk);
        #1;
        check("neg_out1", out1, 8'h3D);
        check("neg_out2", out2, 8'hF1);

        in1 = 8'h78;
        in2 = 8'h11;
        @(posedge clk);
        #1;
`ifdef BUTTERFLY_SUM_SAT_EN
        check("ovf_out1", out1, 8'h79);
        check("ovf_out2", out2, 8'h68);
`else
        check("ovf_out1", out1, 8'h89);
        check("ovf_out2", out2, 8'h67);
`endif

        // Field-boundary extremes.
        in1 = 8'h88;
        in2 = 8'h77;
        @(posedge clk);
        #1;
        check("ext_out1", out1, model(8'h88, 8'h77, 1'b0));
        check("ext_out2", out2, model(8'h88, 8'h77, 1'b1));

        // Latency: inputs changed after an edge must not reach outputs early.
        in1 = 8'h00;
        in2 = 8'h00;
        #2;
        check("no_comb_path_out1", out1, model(8'h88, 8'h77, 1'b0));

        // Random back-to-back stream, one new operand pair per cycle.
        @(posedge clk);
        #1;
        e1 = '0;
        e2 = '0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) begin
                check("rand_out1", out1, e1);
                check("rand_out2", out2, e2);
            end
            in1 = W'($urandom);
            in2 = W'($urandom);
            e1  = model(in1, in2, 1'b0);
            e2  = model(in1, in2, 1'b1);
            @(posedge clk);
            #1;
        end
        check("rand_last_out1", out1, e1);
        check("rand_last_out2", out2, e2);

        // Mid-stream asynchronous reset with nonzero outputs.
        in1 = 8'h31;
        in2 = 8'h21;
        @(posedge clk);
        #1;
        check("pre_rst_out1", out1, 8'h52);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out1", out1, 8'h00);
        check("async_rst_out2", out2, 8'h00);
        @(posedge clk);
        #1;
        check("rst_held_out1", out1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        in1 = 8'h1F;
        in2 = 8'h2E;
        @(posedge clk);
        #1;
        check("resume_out1", out1, 8'h3D);
        check("resume_out2", out2, 8'hF1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
